// File: rtl/plusminus_value_ctrl.sv
// Plus/minus push-button sequencer driving a bounded WIDTH-bit value.
// Ports: clk, rst (sync, active-high); plus_button/minus_button (raw,
// active-low, async); value, step_pulse, step_dir, at_min, at_max.
// Optional auto-repeat: define AUTOREPEAT_EN.
module plusminus_value_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 99,
  parameter int unsigned INIT_VAL      = 0,
  parameter bit          WRAP          = 1'b0,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             plus_button,
  input  logic             minus_button,
  output logic [WIDTH-1:0] value,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             at_min,
  output logic             at_max
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT_VAL);
  localparam logic [CW-1:0] DLAST = CW'(DEB_CYCLES - 1);

  // channel index 1 = plus, 0 = minus
  logic [1:0]         s1;
  logic [1:0]         s2;
  logic [1:0]         lvl;
  logic [1:0]         deb;
  logic [1:0]         req;
  logic [1:0]         flip;
  logic [1:0][CW-1:0] cnt;

  assign lvl = ~s2;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      flip[i] = (lvl[i] != deb[i]) && (cnt[i] == DLAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 2'b11;
      s2  <= 2'b11;
      deb <= 2'b00;
      req <= 2'b00;
      cnt <= '0;
    end else begin
      s1 <= {plus_button, minus_button};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (lvl[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          cnt[i] <= '0;
          deb[i] <= lvl[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        req[i] <= flip[i] & lvl[i];
      end
    end
  end

  logic rep_step;
  logic rep_up;
  logic press_one;
  logic step_req;
  logic step_up;

  assign press_one = req[1] ^ req[0];

  // press edges win; simultaneous presses cancel
  always_comb begin
    step_req = 1'b0;
    step_up  = 1'b0;
    unique case (req)
      2'b10: begin
        step_req = 1'b1;
        step_up  = 1'b1;
      end
      2'b01: begin
        step_req = 1'b1;
        step_up  = 1'b0;
      end
      2'b11: begin
        step_req = 1'b0;
      end
      default: begin
        step_req = rep_step;
        step_up  = rep_up;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  rep_state_t    st;
  rep_state_t    st_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic          rdir;
  logic          rdir_nxt;
  logic          held;
  logic          rlast;

  assign held  = rdir ? deb[1] : deb[0];
  assign rlast = (st == DELAY) ? (rcnt == RD_LAST) : (rcnt == RP_LAST);
  assign rep_up = rdir;

  always_comb begin
    st_nxt   = st;
    rcnt_nxt = rcnt;
    rdir_nxt = rdir;
    rep_step = 1'b0;
    if (press_one && (deb[1] ^ deb[0])) begin
      st_nxt   = DELAY;
      rcnt_nxt = '0;
      rdir_nxt = req[1];
    end else if (st != IDLE) begin
      if (!held || (&deb)) begin
        st_nxt = IDLE;
      end else if (rlast) begin
        rep_step = 1'b1;
        st_nxt   = REPEAT;
        rcnt_nxt = '0;
      end else begin
        rcnt_nxt = rcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      rcnt <= '0;
      rdir <= 1'b0;
    end else begin
      st   <= st_nxt;
      rcnt <= rcnt_nxt;
      rdir <= rdir_nxt;
    end
  end
`else
  assign rep_step = 1'b0;
  assign rep_up   = 1'b0;
`endif

  logic [WIDTH-1:0] nxt;
  logic             changed;

  always_comb begin
    nxt = value;
    if (step_up) begin
      if (value == MAXV) nxt = WRAP ? MINV : MAXV;
      else               nxt = value + 1'b1;
    end else begin
      if (value == MINV) nxt = WRAP ? MAXV : MINV;
      else               nxt = value - 1'b1;
    end
  end

  assign changed = step_req && (nxt != value);

  always_ff @(posedge clk) begin
    if (rst) begin
      value      <= INITV;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
    end else begin
      step_pulse <= changed;
      if (changed) begin
        value    <= nxt;
        step_dir <= step_up;
      end
    end
  end

  assign at_min = (value == MINV);
  assign at_max = (value == MAXV);

endmodule

// File: tb/tb_plusminus_value_ctrl.sv
// Bench for plusminus_value_ctrl: WRAP=0 and WRAP=1 instances in parallel,
// expected steps queued at stimulus time, popped on step_pulse.
module tb_plusminus_value_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       plus_b = 1'b1;
  logic       minus_b = 1'b1;
  logic [7:0] v0, v1;
  logic       p0, p1, d0, d1;
  logic       mn0, mn1, mx0, mx1;

  plusminus_value_ctrl #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .INIT_VAL(5), .WRAP(1'b0),
    .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u0 (
    .clk(clk), .rst(rst), .plus_button(plus_b), .minus_button(minus_b),
    .value(v0), .step_pulse(p0), .step_dir(d0), .at_min(mn0), .at_max(mx0)
  );

  plusminus_value_ctrl #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .INIT_VAL(5), .WRAP(1'b1),
    .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u1 (
    .clk(clk), .rst(rst), .plus_button(plus_b), .minus_button(minus_b),
    .value(v1), .step_pulse(p1), .step_dir(d1), .at_min(mn1), .at_max(mx1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int v;
    bit d;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t e0, e1;
  int  m0 = 5;
  int  m1 = 5;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int v, input bit up, input bit wrap);
    if (up) return (v == 9) ? (wrap ? 0 : 9) : v + 1;
    return (v == 0) ? (wrap ? 9 : 0) : v - 1;
  endfunction

  task automatic push_step(input int t, input bit up);
    int n;
    n = nxt(m0, up, 1'b0);
    if (n != m0) q0.push_back('{t, n, up});
    m0 = n;
    n = nxt(m1, up, 1'b1);
    if (n != m1) q1.push_back('{t, n, up});
    m1 = n;
  endtask

  // d = cycle count when raw level first goes low; released at d+hold
  task automatic expect_hold(input bit up, input int d, input int hold);
    push_step(d + 7, up);
`ifdef AUTOREPEAT_EN
    for (int t = d + 17; t <= d + hold + 6; t += 3) push_step(t, up);
`endif
  endtask

  task automatic press(input bit up, input int hold, input int gap);
    @(negedge clk);
    expect_hold(up, cyc, hold);
    if (up) plus_b = 1'b0;
    else    minus_b = 1'b0;
    repeat (hold) @(negedge clk);
    plus_b  = 1'b1;
    minus_b = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic phase_end(input string tag);
    chk({tag, "_miss0"}, q0.size(), 0);
    chk({tag, "_miss1"}, q1.size(), 0);
    chk({tag, "_val0"}, v0, m0);
    chk({tag, "_val1"}, v1, m1);
    chk({tag, "_min0"}, mn0, (m0 == 0) ? 1 : 0);
    chk({tag, "_max0"}, mx0, (m0 == 9) ? 1 : 0);
    chk({tag, "_min1"}, mn1, (m1 == 0) ? 1 : 0);
    chk({tag, "_max1"}, mx1, (m1 == 9) ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0 = 5;
    m1 = 5;
    chk("rst_val0", v0, 5);
    chk("rst_val1", v1, 5);
    chk("rst_pulse0", p0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && p0) begin
      if (q0.size() == 0) begin
        chk("u0_extra", p0, 0);
      end else begin
        e0 = q0.pop_front();
        chk("u0_cyc", cyc, e0.t);
        chk("u0_val", v0, e0.v);
        chk("u0_dir", d0, e0.d);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && p1) begin
      if (q1.size() == 0) begin
        chk("u1_extra", p1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("u1_cyc", cyc, e1.t);
        chk("u1_val", v1, e1.v);
        chk("u1_dir", d1, e1.d);
      end
    end
  end

  initial begin
    int d;
    repeat (2) @(negedge clk);
    chk("reset_val", v0, 5);
    chk("reset_pulse", p0, 0);
    chk("reset_dir", d0, 0);
    chk("reset_min", mn0, 0);
    chk("reset_max", mx0, 0);
    chk("reset_val1", v1, 5);
    rst = 1'b0;

    press(1'b1, 20, 12);
    phase_end("plus");

    @(negedge clk);
    minus_b = 1'b0;
    repeat (2) @(negedge clk);
    minus_b = 1'b1;
    repeat (2) @(negedge clk);
    press(1'b0, 20, 12);
    phase_end("bounce");

    do_reset();
    for (int i = 0; i < 12 && m0 != 9; i++) press(1'b1, 8, 10);
    press(1'b1, 8, 10);
    phase_end("bound");

    @(negedge clk);
    plus_b  = 1'b0;
    minus_b = 1'b0;
    repeat (10) @(negedge clk);
    plus_b  = 1'b1;
    minus_b = 1'b1;
    repeat (12) @(negedge clk);
    phase_end("both");

    do_reset();
    press(1'b1, 30, 12);
    phase_end("hold");

    @(negedge clk);
    d = cyc;
    push_step(d + 7, 1'b1);
    plus_b = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0 = 5;
    m1 = 5;
    chk("midrst_val0", v0, 5);
    chk("midrst_val1", v1, 5);
    expect_hold(1'b1, cyc, 9);
    repeat (9) @(negedge clk);
    plus_b = 1'b1;
    repeat (12) @(negedge clk);
    phase_end("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
